// File: rtl/operand_fetch_stage_if.sv
// rtl/operand_fetch_stage_if.sv - decode/register-file/writeback/execute bundle for operand_fetch_stage
//   slave : operand fetch stage side (takes in_*, rf_rd_data, wb_*, out_ready)
//   master: environment side (decode, register file, execute)
interface operand_fetch_stage_if #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 4,
    parameter int NUM_OPS = 2,
    parameter int STALL_W = 16
) ();
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_W-1:0]             in_pc;
    logic [7:0]                    in_opcode;
    logic [2*NUM_OPS-1:0]          in_op_mode;
    logic [NUM_OPS-1:0]            in_op_use_base;
    logic [NUM_OPS-1:0]            in_op_use_idx;
    logic [REG_W*NUM_OPS-1:0]      in_op_reg;
    logic [REG_W*NUM_OPS-1:0]      in_op_base;
    logic [2*NUM_OPS-1:0]          in_op_scale;
    logic [DATA_W*NUM_OPS-1:0]     in_op_data;
    logic [2*REG_W*NUM_OPS-1:0]    rf_rd_addr;
    logic [2*DATA_W*NUM_OPS-1:0]   rf_rd_data;
    logic                          wb_valid;
    logic [REG_W-1:0]              wb_reg;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_W-1:0]             out_pc;
    logic [7:0]                    out_opcode;
    logic [DATA_W*NUM_OPS-1:0]     out_ops;
    logic [NUM_OPS-1:0]            out_is_addr;
    logic                          out_dest_is_reg;
    logic [REG_W-1:0]              out_dest_reg;
    logic [STALL_W-1:0]            stall_cnt;

    modport slave (
        input  in_valid, in_pc, in_opcode, in_op_mode, in_op_use_base, in_op_use_idx,
               in_op_reg, in_op_base, in_op_scale, in_op_data, rf_rd_data,
               wb_valid, wb_reg, out_ready,
        output in_ready, rf_rd_addr, out_valid, out_pc, out_opcode, out_ops,
               out_is_addr, out_dest_is_reg, out_dest_reg, stall_cnt
    );

    modport master (
        output in_valid, in_pc, in_opcode, in_op_mode, in_op_use_base, in_op_use_idx,
               in_op_reg, in_op_base, in_op_scale, in_op_data, rf_rd_data,
               wb_valid, wb_reg, out_ready,
        input  in_ready, rf_rd_addr, out_valid, out_pc, out_opcode, out_ops,
               out_is_addr, out_dest_is_reg, out_dest_reg, stall_cnt
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - operand fetch stage with register scoreboard between decode and execute
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : operand_fetch_stage_if.slave (decode in_*, register file rf_*, writeback wb_*, execute out_*)
module operand_fetch_stage #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 4,
    parameter int NUM_OPS = 2,
    parameter int STALL_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    operand_fetch_stage_if.slave  bus
);
    localparam int NUM_REGS = 2**REG_W;
    localparam logic [1:0] MODE_IMM = 2'd1;
    localparam logic [1:0] MODE_REG = 2'd2;
    localparam logic [1:0] MODE_MEM = 2'd3;

    typedef enum logic [1:0] {IDLE, CHECK, CALC, HOLD} state_t;
    state_t state, state_next;

    logic [DATA_W-1:0]           pc_q;
    logic [7:0]                  opcode_q;
    logic [2*NUM_OPS-1:0]        mode_q;
    logic [NUM_OPS-1:0]          use_base_q;
    logic [NUM_OPS-1:0]          use_idx_q;
    logic [REG_W*NUM_OPS-1:0]    reg_q;
    logic [REG_W*NUM_OPS-1:0]    base_q;
    logic [2*NUM_OPS-1:0]        scale_q;
    logic [DATA_W*NUM_OPS-1:0]   data_q;
    logic [2*DATA_W*NUM_OPS-1:0] rf_q;
    logic [NUM_REGS-1:0]         dirty_q;
    logic [NUM_REGS-1:0]         dirty_next;
    logic [NUM_REGS-1:0]         need;
    logic                        stall;
    logic [DATA_W*NUM_OPS-1:0]   ops_calc;
    logic [NUM_OPS-1:0]          is_addr_calc;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == HOLD);

    // Read addresses come from the latched instruction so they stay stable through CHECK.
    always_comb begin
        bus.rf_rd_addr = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            bus.rf_rd_addr[2*REG_W*i +: 2*REG_W] = {base_q[REG_W*i +: REG_W], reg_q[REG_W*i +: REG_W]};
        end
    end

    // Registers actually read by the instruction; op0 in REG mode counts as a read.
    always_comb begin
        need = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (mode_q[2*i +: 2] == MODE_REG) begin
                need[reg_q[REG_W*i +: REG_W]] = 1'b1;
            end else if (mode_q[2*i +: 2] == MODE_MEM) begin
                if (use_base_q[i]) need[base_q[REG_W*i +: REG_W]] = 1'b1;
                if (use_idx_q[i])  need[reg_q[REG_W*i +: REG_W]]  = 1'b1;
            end
        end
    end

    assign stall = (state == CHECK) && |(need & dirty_q);

    // Writeback clears first so that a same-edge destination claim overrides it.
    always_comb begin
        dirty_next = dirty_q;
        if (bus.wb_valid) dirty_next[bus.wb_reg] = 1'b0;
        if (state == CALC && mode_q[1:0] == MODE_REG) dirty_next[reg_q[REG_W-1:0]] = 1'b1;
    end

    // rf_q holds {R[base],R[reg]} per operand as captured at the end of CHECK.
    always_comb begin
        ops_calc     = '0;
        is_addr_calc = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            case (mode_q[2*i +: 2])
                MODE_IMM: ops_calc[DATA_W*i +: DATA_W] = data_q[DATA_W*i +: DATA_W];
                MODE_REG: ops_calc[DATA_W*i +: DATA_W] = rf_q[2*DATA_W*i +: DATA_W];
                MODE_MEM: begin
                    ops_calc[DATA_W*i +: DATA_W] = data_q[DATA_W*i +: DATA_W]
                        + (use_base_q[i] ? rf_q[2*DATA_W*i + DATA_W +: DATA_W] : '0)
                        + (use_idx_q[i]  ? (rf_q[2*DATA_W*i +: DATA_W] << scale_q[2*i +: 2]) : '0);
                    is_addr_calc[i] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = CHECK;
            CHECK:   if (!stall)        state_next = CALC;
            CALC:                       state_next = HOLD;
            HOLD:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q                <= '0;
            opcode_q            <= '0;
            mode_q              <= '0;
            use_base_q          <= '0;
            use_idx_q           <= '0;
            reg_q               <= '0;
            base_q              <= '0;
            scale_q             <= '0;
            data_q              <= '0;
            rf_q                <= '0;
            dirty_q             <= '0;
            bus.stall_cnt       <= '0;
            bus.out_pc          <= '0;
            bus.out_opcode      <= '0;
            bus.out_ops         <= '0;
            bus.out_is_addr     <= '0;
            bus.out_dest_is_reg <= 1'b0;
            bus.out_dest_reg    <= '0;
        end else begin
            dirty_q <= dirty_next;
            if (state == IDLE && bus.in_valid) begin
                pc_q       <= bus.in_pc;
                opcode_q   <= bus.in_opcode;
                mode_q     <= bus.in_op_mode;
                use_base_q <= bus.in_op_use_base;
                use_idx_q  <= bus.in_op_use_idx;
                reg_q      <= bus.in_op_reg;
                base_q     <= bus.in_op_base;
                scale_q    <= bus.in_op_scale;
                data_q     <= bus.in_op_data;
            end
            if (stall && bus.stall_cnt != {STALL_W{1'b1}}) begin
                bus.stall_cnt <= bus.stall_cnt + 1'b1;
            end
            if (state == CHECK && !stall) begin
                rf_q <= bus.rf_rd_data;
            end
            if (state == CALC) begin
                bus.out_pc          <= pc_q;
                bus.out_opcode      <= opcode_q;
                bus.out_ops         <= ops_calc;
                bus.out_is_addr     <= is_addr_calc;
                bus.out_dest_is_reg <= (mode_q[1:0] == MODE_REG);
                bus.out_dest_reg    <= reg_q[REG_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// tb/tb_operand_fetch_stage.sv - self-checking bench for operand_fetch_stage
module tb_operand_fetch_stage;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    operand_fetch_stage_if #(.DATA_W(32), .REG_W(4), .NUM_OPS(2), .STALL_W(16)) ifc ();

    operand_fetch_stage #(.DATA_W(32), .REG_W(4), .NUM_OPS(2), .STALL_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] rf_mem [16];

    always_comb begin
        ifc.rf_rd_data = '0;
        for (int i = 0; i < 2; i++) begin
            ifc.rf_rd_data[64*i +: 64] = {rf_mem[ifc.rf_rd_addr[8*i+4 +: 4]], rf_mem[ifc.rf_rd_addr[8*i +: 4]]};
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [7:0]  opcode;
        logic [3:0]  mode;
        logic [1:0]  use_base;
        logic [1:0]  use_idx;
        logic [7:0]  regs;
        logic [7:0]  base;
        logic [3:0]  scale;
        logic [63:0] data;
        int          hold;
        logic [63:0] exp_ops;
        logic [1:0]  exp_is_addr;
        logic        exp_dest_is_reg;
        logic [3:0]  exp_dest_reg;
    } vec_t;

    vec_t vecs [6];
    vec_t h1, h2, ha, hb;
    int   lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        ifc.in_pc          = v.pc;
        ifc.in_opcode      = v.opcode;
        ifc.in_op_mode     = v.mode;
        ifc.in_op_use_base = v.use_base;
        ifc.in_op_use_idx  = v.use_idx;
        ifc.in_op_reg      = v.regs;
        ifc.in_op_base     = v.base;
        ifc.in_op_scale    = v.scale;
        ifc.in_op_data     = v.data;
        ifc.in_valid       = 1'b1;
        check("in_ready_before_accept", ifc.in_ready, 1);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        check("out_valid_after_accept", ifc.out_valid, 0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!ifc.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_out(input vec_t v);
        check("out_valid", ifc.out_valid, 1);
        check("out_ops", ifc.out_ops, v.exp_ops);
        check("out_is_addr", ifc.out_is_addr, v.exp_is_addr);
        check("out_dest_is_reg", ifc.out_dest_is_reg, v.exp_dest_is_reg);
        check("out_dest_reg", ifc.out_dest_reg, v.exp_dest_reg);
        check("out_pc", ifc.out_pc, v.pc);
        check("out_opcode", ifc.out_opcode, v.opcode);
    endtask

    task automatic hold_and_release(input vec_t v);
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            check("hold_out_valid", ifc.out_valid, 1);
            check("hold_in_ready", ifc.in_ready, 0);
            check("hold_out_ops", ifc.out_ops, v.exp_ops);
            check("hold_out_pc", ifc.out_pc, v.pc);
        end
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        check("release_out_valid", ifc.out_valid, 0);
        check("release_in_ready", ifc.in_ready, 1);
    endtask

    task automatic wb_pulse(input logic [3:0] r);
        ifc.wb_valid = 1'b1;
        ifc.wb_reg   = r;
        @(negedge clk);
        ifc.wb_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 16; i++) rf_mem[i] = 32'h0101 * i;
        rf_mem[0] = 32'hDEAD_0000;
        rf_mem[1] = 32'h5;
        rf_mem[2] = 32'h1000;
        rf_mem[3] = 32'h3;
        rf_mem[4] = 32'hFFFF_FFF0;
        rf_mem[5] = 32'h55;
        rf_mem[6] = 32'h66;

        //          pc        opc    mode     ub     ui     regs   base   scale    data                         hold exp_ops                      is     dr    dreg
        vecs[0] = '{32'h100, 8'h40, 4'b0101, 2'b00, 2'b00, 8'h00, 8'h00, 4'b0000, {32'hABCD, 32'h1234},        0, {32'hABCD, 32'h1234},        2'b00, 1'b0, 4'h0};
        vecs[1] = '{32'h104, 8'h41, 4'b1100, 2'b10, 2'b10, 8'h30, 8'h20, 4'b1000, {32'h20, 32'hFFFF_FFFF},     6, {32'h102C, 32'h0},           2'b10, 1'b0, 4'h0};
        vecs[2] = '{32'h108, 8'h42, 4'b1011, 2'b01, 2'b00, 8'h20, 8'h04, 4'b0000, {32'h0, 32'h20},             1, {32'h1000, 32'h10},          2'b01, 1'b0, 4'h0};
        vecs[3] = '{32'h10C, 8'h43, 4'b1110, 2'b00, 2'b10, 8'h35, 8'h00, 4'b1100, {32'h100, 32'h0},            0, {32'h118, 32'h55},           2'b10, 1'b1, 4'h5};
        vecs[4] = '{32'h110, 8'h44, 4'b1110, 2'b10, 2'b10, 8'h00, 8'h00, 4'b0100, {32'h1, 32'h0},              2, {32'h9C07_0001, 32'hDEAD_0000}, 2'b10, 1'b1, 4'h0};
        vecs[5] = '{32'h114, 8'h45, 4'b0011, 2'b00, 2'b00, 8'h0F, 8'h00, 4'b0000, {32'hFFFF, 32'h8000_0000},   0, {32'h0, 32'h8000_0000},      2'b01, 1'b0, 4'hF};

        h1 = '{32'h200, 8'h10, 4'b0110, 2'b00, 2'b00, 8'h01, 8'h00, 4'b0000, {32'h10, 32'h0}, 0, {32'h10, 32'h5}, 2'b00, 1'b1, 4'h1};
        h2 = '{32'h204, 8'h11, 4'b1000, 2'b00, 2'b00, 8'h10, 8'h00, 4'b0000, {32'h0, 32'h0},  0, {32'h5, 32'h0},  2'b00, 1'b0, 4'h0};
        ha = '{32'h300, 8'h20, 4'b0010, 2'b00, 2'b00, 8'h06, 8'h00, 4'b0000, {32'h0, 32'h0},  0, {32'h0, 32'h66}, 2'b00, 1'b1, 4'h6};
        hb = '{32'h304, 8'h21, 4'b1000, 2'b00, 2'b00, 8'h60, 8'h00, 4'b0000, {32'h0, 32'h0},  0, {32'h66, 32'h0}, 2'b00, 1'b0, 4'h0};

        reset = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_pc = '0;
        ifc.in_opcode = '0;
        ifc.in_op_mode = '0;
        ifc.in_op_use_base = '0;
        ifc.in_op_use_idx = '0;
        ifc.in_op_reg = '0;
        ifc.in_op_base = '0;
        ifc.in_op_scale = '0;
        ifc.in_op_data = '0;
        ifc.wb_valid = 1'b0;
        ifc.wb_reg = '0;
        ifc.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("reset_in_ready", ifc.in_ready, 1);
        check("reset_out_valid", ifc.out_valid, 0);
        check("reset_stall_cnt", ifc.stall_cnt, 0);
        check("reset_out_ops", ifc.out_ops, 0);

        // Destination r1 goes dirty; out_valid after two more edges.
        send(h1);
        wait_valid(lat);
        check("t1_latency", lat, 2);
        check_out(h1);
        hold_and_release(h1);

        // Reader of dirty r1 stalls until writeback; one stall cycle per edge spent in CHECK.
        send(h2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t2_stalled", ifc.out_valid, 0);
        end
        check("t2_stall_cnt_4", ifc.stall_cnt, 4);
        ifc.wb_valid = 1'b1;
        ifc.wb_reg   = 4'h1;
        @(negedge clk);
        ifc.wb_valid = 1'b0;
        check("t2_stall_cnt_5", ifc.stall_cnt, 5);
        @(negedge clk);
        check("t2_calc_not_valid", ifc.out_valid, 0);
        check("t2_stall_cnt_held", ifc.stall_cnt, 5);
        @(negedge clk);
        check_out(h2);
        hold_and_release(h2);

        for (int v = 0; v < 6; v++) begin
            send(vecs[v]);
            wait_valid(lat);
            check("vec_latency", lat, 2);
            check_out(vecs[v]);
            hold_and_release(vecs[v]);
            if (vecs[v].exp_dest_is_reg) wb_pulse(vecs[v].exp_dest_reg);
        end
        check("stall_cnt_after_table", ifc.stall_cnt, 5);

        // Reset during CHECK drops the stalled instruction and clears scoreboard and counter.
        send(ha);
        wait_valid(lat);
        check("ta_latency", lat, 2);
        check_out(ha);
        hold_and_release(ha);
        send(hb);
        repeat (3) @(negedge clk);
        check("tb_stalled", ifc.out_valid, 0);
        check("tb_stall_cnt", ifc.stall_cnt, 8);
        pulse_reset();
        check("rst_check_out_valid", ifc.out_valid, 0);
        check("rst_check_in_ready", ifc.in_ready, 1);
        check("rst_check_stall_cnt", ifc.stall_cnt, 0);
        send(hb);
        wait_valid(lat);
        check("rst_check_scoreboard_clean", lat, 2);
        check_out(hb);

        // Reset during HOLD.
        pulse_reset();
        check("rst_hold_out_valid", ifc.out_valid, 0);
        check("rst_hold_in_ready", ifc.in_ready, 1);
        check("rst_hold_out_ops", ifc.out_ops, 0);
        check("rst_hold_out_pc", ifc.out_pc, 0);
        check("rst_hold_stall_cnt", ifc.stall_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
